// File: rtl/spi_slave_if.sv
// SPI-slave byte engine (mode 0, 8-bit frames): synchronizes the SPI pins into clk,
// assembles MSB-first bytes for the command decoder and shifts a response byte out.
module spi_slave_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       sck_i,
  input  logic       ncs_i,
  input  logic       sdi_i,
  output logic       sdo_o,
  output logic [7:0] spi_data_o,
  output logic       rxne_o,
  input  logic       rx_ack_i,
  output logic       ovr_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_load_i,
  output logic       busy_o,
  output logic       tc_o,
  output logic       rdy_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, ncs_sync_q, sdi_sync_q;
  logic sck_prev_q, ncs_prev_q;
  logic sck_s, ncs_s, sdi_s;
  logic sck_rise, sck_fall, ncs_rise, ncs_fall;

  logic [7:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, tx_buf_q, tx_buf_d;
  logic [7:0] spi_data_q, spi_data_d, rx_byte;
  logic [2:0] cnt_q, cnt_d;
  logic tx_full_q, tx_full_d, got_byte_q, got_byte_d;
  logic rxne_q, rxne_d, ovr_q, ovr_d, tc_q, tc_d, rdy_q, rdy_d;
  logic byte_done, tx_copy;

  // ncs synchronizer resets to the inactive level so a low pin after reset reads as a fall
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sck_sync_q <= '0;
      ncs_sync_q <= '1;
      sdi_sync_q <= '0;
      sck_prev_q <= 1'b0;
      ncs_prev_q <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      ncs_sync_q <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_i};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
      sck_prev_q <= sck_s;
      ncs_prev_q <= ncs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ncs_s    = ncs_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ncs_rise = ncs_s & ~ncs_prev_q;
  assign ncs_fall = ~ncs_s & ncs_prev_q;
  assign rx_byte  = {rx_sh_q[6:0], sdi_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    got_byte_d = got_byte_q;
    spi_data_d = spi_data_q;
    rxne_d     = rxne_q;
    ovr_d      = ovr_q;
    tc_d       = 1'b0;
    byte_done  = 1'b0;
    tx_copy    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d      = 3'd0;
        got_byte_d = 1'b0;
        if (ncs_fall) begin
          state_d = ACTIVE;
          tx_copy = 1'b1;
        end
      end
      ACTIVE: begin
        if (ncs_rise) begin
          state_d = DONE;
        end else if (sck_rise) begin
          rx_sh_d = rx_byte;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            byte_done  = 1'b1;
            got_byte_d = 1'b1;
          end
        end else if (sck_fall) begin
          // counter back at 0 after a finished byte: next response byte goes out
          if (cnt_q == 3'd0 && got_byte_q) tx_copy = 1'b1;
          else tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
      DONE: begin
        state_d    = IDLE;
        cnt_d      = 3'd0;
        tc_d       = got_byte_q;
        got_byte_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (tx_copy) begin
      tx_sh_d   = tx_full_q ? tx_buf_q : 8'h00;
      tx_full_d = 1'b0;
    end
    if (tx_load_i) begin
      tx_buf_d  = tx_data_i;
      tx_full_d = 1'b1;
    end

    // an acknowledge landing with a completed byte frees the slot for that byte
    if (byte_done) begin
      if (rx_ack_i || !rxne_q) begin
        spi_data_d = rx_byte;
        rxne_d     = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_ack_i) begin
      rxne_d = 1'b0;
      ovr_d  = 1'b0;
    end

    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      rx_sh_q    <= 8'h00;
      tx_sh_q    <= 8'h00;
      tx_buf_q   <= 8'h00;
      tx_full_q  <= 1'b0;
      got_byte_q <= 1'b0;
      spi_data_q <= 8'h00;
      rxne_q     <= 1'b0;
      ovr_q      <= 1'b0;
      tc_q       <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      got_byte_q <= got_byte_d;
      spi_data_q <= spi_data_d;
      rxne_q     <= rxne_d;
      ovr_q      <= ovr_d;
      tc_q       <= tc_d;
      rdy_q      <= rdy_d;
    end
  end

  assign sdo_o      = (state_q == ACTIVE) & tx_sh_q[7];
  assign spi_data_o = spi_data_q;
  assign rxne_o     = rxne_q;
  assign ovr_o      = ovr_q;
  assign busy_o     = (state_q != IDLE);
  assign tc_o       = tc_q;
  assign rdy_o      = rdy_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: acts as a mode-0 SPI master with sck = 8x slower than clk,
// all pin changes on clk falling edges so DUT outputs are sampled away from the rising edge.
module tb_spi_slave_if;

  logic       clock = 1'b0;
  logic       nrst, sck, ncs, sdi, sdo, rxAck, txLoad;
  logic       rxne, ovr, busy, tc, rdy;
  logic [7:0] spiData, txData, miso1, miso2;
  int         checkCount = 0;
  int         passCount  = 0;

  always #5 clock = ~clock;

  spi_slave_if #(.SYNC_STAGES(2)) dut (
    .clk_i(clock), .nrst_i(nrst), .sck_i(sck), .ncs_i(ncs), .sdi_i(sdi), .sdo_o(sdo),
    .spi_data_o(spiData), .rxne_o(rxne), .rx_ack_i(rxAck), .ovr_o(ovr),
    .tx_data_i(txData), .tx_load_i(txLoad), .busy_o(busy), .tc_o(tc), .rdy_o(rdy)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, obs, exp, $time);
  endtask

  // Shifts n bits of b MSB-first; on the last bit optionally checks the rxne latency and/or
  // pulses rx_ack so it lands on the clk edge that completes the byte (3 edges after sck rise).
  task automatic applyStimulus(input logic [7:0] b, input int n, input bit doTiming,
                               input bit ackOnLast, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 0; i < n; i++) begin
      sdi = b[7-i];
      miso[7-i] = sdo;
      sck = 1'b1;
      if (i == n - 1) begin
        #20;
        if (doTiming) checkOutput("rxne_before_detect", {7'd0, rxne}, 8'h00);
        if (ackOnLast) rxAck = 1'b1;
        #10;
        rxAck = 1'b0;
        if (doTiming) begin
          checkOutput("rxne_at_detect", {7'd0, rxne}, 8'h01);
          checkOutput("data_at_detect", spiData, b);
        end
        #10;
      end else begin
        #40;
      end
      sck = 1'b0;
      #40;
    end
  endtask

  task automatic startFrame();
    @(negedge clock);
    ncs = 1'b0;
    #80;
  endtask

  task automatic endFrame(input logic expTc);
    ncs = 1'b1;
    #30;
    checkOutput("tc_low_in_done", {7'd0, tc}, 8'h00);
    checkOutput("busy_in_done", {7'd0, busy}, 8'h01);
    #10;
    checkOutput("tc_pulse", {7'd0, tc}, {7'd0, expTc});
    checkOutput("busy_after_frame", {7'd0, busy}, 8'h00);
    checkOutput("rdy_after_frame", {7'd0, rdy}, 8'h01);
    #10;
    checkOutput("tc_one_cycle", {7'd0, tc}, 8'h00);
    #40;
  endtask

  task automatic pulseAck();
    @(negedge clock);
    rxAck = 1'b1;
    @(negedge clock);
    rxAck = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; ncs = 1'b1; sck = 1'b0; sdi = 1'b0;
    rxAck = 1'b0; txLoad = 1'b0; txData = 8'h00;
    #20;
    checkOutput("reset_rdy", {7'd0, rdy}, 8'h00);
    checkOutput("reset_busy", {7'd0, busy}, 8'h00);
    checkOutput("reset_data", spiData, 8'h00);
    @(negedge clock);
    nrst = 1'b1;
    #10;
    checkOutput("rdy_after_release", {7'd0, rdy}, 8'h01);
    #30;

    $display("[TB] frame 0xA5 with latency check");
    startFrame();
    checkOutput("busy_in_frame", {7'd0, busy}, 8'h01);
    applyStimulus(8'hA5, 8, 1'b1, 1'b0, miso1);
    checkOutput("sdo_empty_buffer", miso1, 8'h00);
    endFrame(1'b1);
    checkOutput("ovr_after_a5", {7'd0, ovr}, 8'h00);
    pulseAck();

    $display("[TB] tx_load 0x3C then two-byte frame");
    @(negedge clock);
    txData = 8'h3C; txLoad = 1'b1;
    @(negedge clock);
    txLoad = 1'b0; txData = 8'h00;
    startFrame();
    applyStimulus(8'h01, 8, 1'b0, 1'b0, miso1);
    checkOutput("busy_mid_frame", {7'd0, busy}, 8'h01);
    checkOutput("rdy_mid_frame", {7'd0, rdy}, 8'h00);
    applyStimulus(8'h02, 8, 1'b0, 1'b0, miso2);
    checkOutput("sdo_byte0", miso1, 8'h3C);
    checkOutput("sdo_byte1", miso2, 8'h00);
    endFrame(1'b1);
    pulseAck();

    $display("[TB] overrun 0x11 0x22");
    startFrame();
    applyStimulus(8'h11, 8, 1'b0, 1'b0, miso1);
    applyStimulus(8'h22, 8, 1'b0, 1'b0, miso1);
    endFrame(1'b1);
    checkOutput("ovr_data", spiData, 8'h11);
    checkOutput("ovr_rxne", {7'd0, rxne}, 8'h01);
    checkOutput("ovr_flag", {7'd0, ovr}, 8'h01);
    pulseAck();
    #10;
    checkOutput("ack_rxne", {7'd0, rxne}, 8'h00);
    checkOutput("ack_ovr", {7'd0, ovr}, 8'h00);
    startFrame();
    applyStimulus(8'h33, 8, 1'b0, 1'b0, miso1);
    endFrame(1'b1);
    checkOutput("data_33", spiData, 8'h33);
    pulseAck();

    $display("[TB] partial frame then 0x5A");
    startFrame();
    applyStimulus(8'hF8, 5, 1'b0, 1'b0, miso1);
    endFrame(1'b0);
    checkOutput("partial_rxne", {7'd0, rxne}, 8'h00);
    checkOutput("partial_ovr", {7'd0, ovr}, 8'h00);
    checkOutput("partial_data", spiData, 8'h33);
    startFrame();
    applyStimulus(8'h5A, 8, 1'b0, 1'b0, miso1);
    endFrame(1'b1);
    checkOutput("data_5a", spiData, 8'h5A);
    pulseAck();

    $display("[TB] rx_ack coincident with second byte");
    startFrame();
    applyStimulus(8'h77, 8, 1'b0, 1'b0, miso1);
    applyStimulus(8'h88, 8, 1'b0, 1'b1, miso1);
    checkOutput("coinc_rxne", {7'd0, rxne}, 8'h01);
    checkOutput("coinc_data", spiData, 8'h88);
    checkOutput("coinc_ovr", {7'd0, ovr}, 8'h00);
    endFrame(1'b1);

    $display("[TB] reset mid-frame");
    startFrame();
    applyStimulus(8'hFF, 4, 1'b0, 1'b0, miso1);
    sck = 1'b1;
    #20;
    nrst = 1'b0;
    sck = 1'b0;
    #5;
    checkOutput("midrst_data", spiData, 8'h00);
    checkOutput("midrst_rxne", {7'd0, rxne}, 8'h00);
    checkOutput("midrst_ovr", {7'd0, ovr}, 8'h00);
    checkOutput("midrst_tc", {7'd0, tc}, 8'h00);
    checkOutput("midrst_busy", {7'd0, busy}, 8'h00);
    checkOutput("midrst_rdy", {7'd0, rdy}, 8'h00);
    checkOutput("midrst_sdo", {7'd0, sdo}, 8'h00);
    @(negedge clock);
    nrst = 1'b1;
    #40;
    checkOutput("restart_busy", {7'd0, busy}, 8'h01);
    #40;
    applyStimulus(8'hC3, 8, 1'b0, 1'b0, miso1);
    endFrame(1'b1);
    checkOutput("data_c3", spiData, 8'hC3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
